// File: rtl/jtag_seq_master_if.sv
// ---------------------------------------------------------------------------
// jtag_seq_master_if
//
// Command/response bus between a command issuer and the JTAG sequencer.
//   cmd_valid / cmd_ready : command handshake; a command is taken on the
//                           edge where both are high
//   cmd_op                : 00 RESET, 01 SHIFT_IR, 10 SHIFT_DR, 11 IDLE
//   cmd_len               : shift bits or idle cycles (legal 1..DATA_W)
//   cmd_data              : TDI bits, shifted LSB first
//   rsp_valid             : one-cycle completion pulse (no backpressure)
//   rsp_err               : qualifies rsp_valid; illegal length
//   rsp_data              : captured TDO, right-justified
//
// Modports: master = command issuer, slave = sequencer.
// DATA_W and LEN_W must match the jtag_seq_master instance they connect to.
// ---------------------------------------------------------------------------
interface jtag_seq_master_if #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [LEN_W-1:0]  cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data,
        input  cmd_ready, rsp_valid, rsp_err, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data,
        output cmd_ready, rsp_valid, rsp_err, rsp_data
    );
endinterface

// File: rtl/jtag_seq_master.sv
// ---------------------------------------------------------------------------
// jtag_seq_master
//
// Command-driven JTAG sequencer. Generates registered TMS/TDI for a TAP
// that shares clk (TCK) and TRST, walks it through reset / IR-shift /
// DR-shift / idle sequences that all start and end in Run-Test/Idle,
// captures TDO during shift cycles and keeps a shadow copy of the TAP state.
//
// Ports:
//   clk       : TCK, shared with the TAP
//   TRST      : asynchronous, active-high reset
//   bus       : command/response bus (slave side)
//   TMS, TDI  : registered JTAG outputs
//   TDO       : serial data from the scanned device
//   tap_state : shadow TAP state (0 TLR ... 15 UpdIR)
//
// Assumes DATA_W >= 8 (head index fits the shift counter) and that LEN_W
// is at least $clog2(DATA_W).
// ---------------------------------------------------------------------------
module jtag_seq_master #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic                clk,
    input  logic                TRST,
    jtag_seq_master_if.slave    bus,
    output logic                TMS,
    output logic                TDI,
    input  logic                TDO,
    output logic [3:0]          tap_state
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(DATA_W);

    typedef enum logic [1:0] {
        OP_RESET = 2'b00, OP_SHIFT_IR = 2'b01, OP_SHIFT_DR = 2'b10, OP_IDLE = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        TAP_TLR, TAP_IDLE, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR,
        TAP_PAUSE_DR, TAP_EX2_DR, TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR,
        TAP_SH_IR, TAP_EX1_IR, TAP_PAUSE_IR, TAP_EX2_IR, TAP_UPD_IR
    } tap_t;

    // HEAD/SHIFT/TAIL are the phases of a TMS sequence; cnt indexes the
    // next bit to emit within the current phase.
    typedef enum logic [2:0] {
        ST_INIT, ST_READY, ST_HEAD, ST_SHIFT, ST_TAIL, ST_DONE, ST_ERR
    } fsm_t;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TAP_TLR:      return tms ? TAP_TLR      : TAP_IDLE;
            TAP_IDLE:     return tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_DR:   return tms ? TAP_SEL_IR   : TAP_CAP_DR;
            TAP_CAP_DR:   return tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_SH_DR:    return tms ? TAP_EX1_DR   : TAP_SH_DR;
            TAP_EX1_DR:   return tms ? TAP_UPD_DR   : TAP_PAUSE_DR;
            TAP_PAUSE_DR: return tms ? TAP_EX2_DR   : TAP_PAUSE_DR;
            TAP_EX2_DR:   return tms ? TAP_UPD_DR   : TAP_SH_DR;
            TAP_UPD_DR:   return tms ? TAP_SEL_DR   : TAP_IDLE;
            TAP_SEL_IR:   return tms ? TAP_TLR      : TAP_CAP_IR;
            TAP_CAP_IR:   return tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_SH_IR:    return tms ? TAP_EX1_IR   : TAP_SH_IR;
            TAP_EX1_IR:   return tms ? TAP_UPD_IR   : TAP_PAUSE_IR;
            TAP_PAUSE_IR: return tms ? TAP_EX2_IR   : TAP_PAUSE_IR;
            TAP_EX2_IR:   return tms ? TAP_UPD_IR   : TAP_SH_IR;
            default:      return tms ? TAP_SEL_DR   : TAP_IDLE;
        endcase
    endfunction

    fsm_t              state;
    tap_t              tap_q;
    op_t               op_q;
    logic [LEN_W-1:0]  len_q;
    logic [DATA_W-1:0] data_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cap;
    logic [CNT_W-1:0]  cap_idx;

    // The bit emitted at an accept edge comes from the incoming command;
    // afterwards it comes from the latched copy. Both paths share one
    // sequence generator so bit 0 is registered on the accept edge itself.
    logic              accept;
    logic              len_bad;
    fsm_t              pos;
    op_t               cur_op;
    logic [LEN_W-1:0]  cur_len;
    logic [DATA_W-1:0] cur_data;
    logic [CNT_W-1:0]  cur_cnt;
    logic [CNT_W-1:0]  head_last;
    logic              last_shift;
    logic              nxt_tms;
    logic              nxt_tdi;
    fsm_t              nxt_state;
    logic [CNT_W-1:0]  nxt_cnt;

    assign accept    = (state == ST_READY) && bus.cmd_valid;
    assign tap_state = tap_q;

    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would otherwise infer a latch.
    always_comb begin
        cur_op     = accept ? op_t'(bus.cmd_op) : op_q;
        cur_len    = accept ? bus.cmd_len       : len_q;
        cur_data   = accept ? bus.cmd_data      : data_q;
        cur_cnt    = accept ? '0                : cnt;
        pos        = state;
        nxt_tms    = 1'b0;
        nxt_tdi    = 1'b0;
        nxt_state  = state;
        nxt_cnt    = cur_cnt;
        head_last  = CNT_W'(2);
        len_bad    = (cur_op != OP_RESET) &&
                     ((cur_len == '0) || ({1'b0, cur_len} > MAX_LEN));
        last_shift = (LEN_W'(cur_cnt) == cur_len - LEN_W'(1));

        if (accept)
            pos = (cur_op == OP_IDLE) ? ST_SHIFT : ST_HEAD;

        case (cur_op)
            OP_RESET:    head_last = CNT_W'(4);
            OP_SHIFT_IR: head_last = CNT_W'(3);
            default:     head_last = CNT_W'(2);
        endcase

        case (pos)
            ST_HEAD: begin
                // RESET: 1,1,1,1,1   SHIFT_DR: 1,0,0   SHIFT_IR: 1,1,0,0
                case (cur_op)
                    OP_RESET:    nxt_tms = 1'b1;
                    OP_SHIFT_IR: nxt_tms = (cur_cnt < CNT_W'(2));
                    default:     nxt_tms = (cur_cnt == '0);
                endcase
                if (cur_cnt == head_last) begin
                    nxt_state = (cur_op == OP_RESET) ? ST_TAIL : ST_SHIFT;
                    nxt_cnt   = '0;
                end else begin
                    nxt_state = ST_HEAD;
                    nxt_cnt   = cur_cnt + CNT_W'(1);
                end
            end
            ST_SHIFT: begin
                // The last shift bit carries TMS=1 to leave Shift-xR; IDLE
                // reuses this phase as a plain cycle counter with TMS=0.
                nxt_tms = (cur_op != OP_IDLE) && last_shift;
                nxt_tdi = (cur_op != OP_IDLE) && cur_data[cur_cnt];
                if (last_shift) begin
                    nxt_state = (cur_op == OP_IDLE) ? ST_DONE : ST_TAIL;
                    nxt_cnt   = '0;
                end else begin
                    nxt_state = ST_SHIFT;
                    nxt_cnt   = cur_cnt + CNT_W'(1);
                end
            end
            ST_TAIL: begin
                // Shifts: Exit1 -> Update (1), Update -> Idle (0).
                // RESET: TLR -> Idle (0).
                nxt_tms = (cur_op != OP_RESET) && (cur_cnt == '0);
                if ((cur_op == OP_RESET) || (cur_cnt != '0)) begin
                    nxt_state = ST_DONE;
                    nxt_cnt   = '0;
                end else begin
                    nxt_state = ST_TAIL;
                    nxt_cnt   = cur_cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register here samples values from before the edge.
    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) begin
            state         <= ST_INIT;
            tap_q         <= TAP_TLR;
            op_q          <= OP_RESET;
            len_q         <= '0;
            data_q        <= '0;
            cnt           <= '0;
            cap           <= '0;
            cap_idx       <= '0;
            TMS           <= 1'b0;
            TDI           <= 1'b0;
            bus.cmd_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            // Shadow follows the TMS the TAP samples on this same edge.
            tap_q         <= tap_next(tap_q, TMS);
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;

            // The TAP consumes a shift bit on every edge it spends in
            // Shift-xR; TDO for that bit is valid on the same edge.
            if ((state == ST_HEAD || state == ST_SHIFT || state == ST_TAIL) &&
                (tap_q == TAP_SH_DR || tap_q == TAP_SH_IR)) begin
                cap[cap_idx] <= TDO;
                cap_idx      <= cap_idx + CNT_W'(1);
            end

            case (state)
                ST_INIT: begin
                    TMS           <= 1'b0;
                    TDI           <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                    state         <= ST_READY;
                end
                ST_READY: begin
                    TMS <= 1'b0;
                    TDI <= 1'b0;
                    if (accept) begin
                        op_q          <= cur_op;
                        len_q         <= cur_len;
                        data_q        <= cur_data;
                        cap           <= '0;
                        cap_idx       <= '0;
                        bus.cmd_ready <= 1'b0;
                        if (len_bad) begin
                            state <= ST_ERR;
                        end else begin
                            TMS   <= nxt_tms;
                            TDI   <= nxt_tdi;
                            state <= nxt_state;
                            cnt   <= nxt_cnt;
                        end
                    end
                end
                ST_HEAD, ST_SHIFT, ST_TAIL: begin
                    TMS   <= nxt_tms;
                    TDI   <= nxt_tdi;
                    state <= nxt_state;
                    cnt   <= nxt_cnt;
                end
                ST_DONE: begin
                    TMS           <= 1'b0;
                    TDI           <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_data  <= cap;
                    bus.cmd_ready <= 1'b1;
                    state         <= ST_READY;
                end
                default: begin // ST_ERR
                    TMS           <= 1'b0;
                    TDI           <= 1'b0;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b1;
                    bus.rsp_data  <= '0;
                    bus.cmd_ready <= 1'b1;
                    state         <= ST_READY;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jtag_seq_master.sv
// ---------------------------------------------------------------------------
// tb_jtag_seq_master
//
// Self-checking bench for jtag_seq_master. Each command is built into an
// expected TMS/TDI bit list from the sequence rules, a table-driven TAP
// model tracks the expected state, and TDO is captured by the model while
// it sits in Shift-DR/Shift-IR. Directed vectors carry hand-derived response
// data, error flag and latency; random commands rely on the model alone.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtag_seq_master;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;

    logic       clk;
    logic       TRST;
    logic       TMS;
    logic       TDI;
    logic       TDO;
    logic [3:0] tap_state;

    // TDO source: 0/1 constant, 2 loopback of TDI, 3 random per cycle
    int   tdo_mode;
    logic tdo_drv;

    int n_checks;
    int n_fail;
    int cyc;
    int mtap;
    logic [31:0] last_rsp;
    int acc_cyc;
    int rsp_cyc;
    logic [1:0]  nh_op;
    int          nh_len;
    logic [31:0] nh_data;

    // Standard TAP transition table, indexed by state, for TMS=0 and TMS=1
    int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};

    typedef struct {
        logic [1:0]  op;
        int          len;
        logic [31:0] data;
        int          mode;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    jtag_seq_master_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus();

    jtag_seq_master #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .TRST      (TRST),
        .bus       (bus),
        .TMS       (TMS),
        .TDI       (TDI),
        .TDO       (TDO),
        .tap_state (tap_state)
    );

    assign TDO = (tdo_mode == 2) ? TDI : tdo_drv;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Caller is at a negedge with cmd_ready expected high. Returns at the
    // negedge after the response edge.
    task automatic run_cmd(input logic [1:0] op, input int len, input logic [31:0] data,
                           input int mode, input bit hold,
                           output logic [31:0] got_data, output logic got_err,
                           output int got_lat);
        bit          tms_q[$];
        bit          tdi_q[$];
        bit          bad;
        int          L;
        int          ci;
        logic [31:0] exp_cap;
        bit          cur_tms;
        bit          cur_tdi;
        bit          tdo_now;

        bad = (op != 2'b00) && (len < 1 || len > DATA_W);
        if (!bad) begin
            case (op)
                2'b00:   tms_q = '{1, 1, 1, 1, 1, 0};
                2'b10:   tms_q = '{1, 0, 0};
                2'b01:   tms_q = '{1, 1, 0, 0};
                default: tms_q = {};
            endcase
            for (int i = 0; i < tms_q.size(); i++) tdi_q.push_back(1'b0);
            if (op != 2'b00) begin
                for (int i = 0; i < len; i++) begin
                    tms_q.push_back((op != 2'b11) && (i == len - 1));
                    tdi_q.push_back((op != 2'b11) && data[i]);
                end
            end
            if (op == 2'b01 || op == 2'b10) begin
                tms_q.push_back(1'b1); tdi_q.push_back(1'b0);
                tms_q.push_back(1'b0); tdi_q.push_back(1'b0);
            end
        end
        L = bad ? 1 : tms_q.size();

        check("ready_before_cmd", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = LEN_W'(len);
        bus.cmd_data  = data;
        tdo_mode      = mode;
        tdo_drv       = (mode == 3) ? 1'($urandom) : mode[0];
        tdo_now       = tdo_drv;
        cur_tms       = 1'b0;
        cur_tdi       = 1'b0;
        exp_cap       = '0;
        ci            = 0;
        got_lat       = -1;
        got_data      = '0;
        got_err       = 1'b0;

        for (int e = 0; e <= L; e++) begin
            @(posedge clk);
            if (mtap == 4 || mtap == 11) begin
                exp_cap[ci] = tdo_now;
                ci++;
            end
            mtap    = cur_tms ? nx1[mtap] : nx0[mtap];
            cur_tms = (!bad && e < L) ? tms_q[e] : 1'b0;
            cur_tdi = (!bad && e < L) ? tdi_q[e] : 1'b0;
            @(negedge clk);
            if (e == 0) begin
                acc_cyc = cyc;
                if (hold) begin
                    bus.cmd_op   = nh_op;
                    bus.cmd_len  = LEN_W'(nh_len);
                    bus.cmd_data = nh_data;
                end else begin
                    bus.cmd_valid = 1'b0;
                    bus.cmd_op    = 2'($urandom);
                    bus.cmd_len   = LEN_W'($urandom);
                    bus.cmd_data  = $urandom;
                end
            end else if (e < L && !hold) begin
                // Requests while busy must be ignored.
                bus.cmd_valid = 1'($urandom);
            end
            check($sformatf("tms e=%0d", e), TMS, cur_tms);
            check($sformatf("tdi e=%0d", e), TDI, cur_tdi);
            check($sformatf("tap_state e=%0d", e), tap_state, mtap);
            check($sformatf("rsp_valid e=%0d", e), bus.rsp_valid, (e == L));
            check($sformatf("cmd_ready e=%0d", e), bus.cmd_ready, (e == L));
            if (bus.rsp_valid && got_lat < 0) got_lat = e;
            if (e < L) begin
                check($sformatf("rsp_data_hold e=%0d", e), bus.rsp_data, last_rsp);
            end else begin
                got_data = bus.rsp_data;
                got_err  = bus.rsp_err;
                check("rsp_data_model", bus.rsp_data, exp_cap);
                check("rsp_err_model", bus.rsp_err, bad);
                last_rsp      = exp_cap;
                rsp_cyc       = cyc;
                bus.cmd_valid = hold;
            end
            if (mode == 3) tdo_drv = 1'($urandom);
            tdo_now = (mode == 2) ? cur_tdi : tdo_drv;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tms"}, TMS, 0);
        check({tag, " tdi"}, TDI, 0);
        check({tag, " cmd_ready"}, bus.cmd_ready, 0);
        check({tag, " rsp_valid"}, bus.rsp_valid, 0);
        check({tag, " rsp_err"}, bus.rsp_err, 0);
        check({tag, " rsp_data"}, bus.rsp_data, 0);
        check({tag, " tap_state"}, tap_state, 0);
    endtask

    // Called at a negedge with TRST high; releases and checks INIT -> READY.
    task automatic release_reset();
        TRST = 1'b0;
        @(posedge clk);
        mtap = nx0[mtap];
        @(negedge clk);
        check("post_reset tap_state", tap_state, 1);
        check("post_reset cmd_ready", bus.cmd_ready, 1);
        check("post_reset tms", TMS, 0);
    endtask

    initial begin
        logic [31:0] gd;
        logic        ge;
        int          gl;
        int          a0;

        n_checks = 0;
        n_fail   = 0;
        tdo_mode = 0;
        tdo_drv  = 1'b0;
        last_rsp = '0;
        mtap     = 0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        TRST = 1'b1;

        //          op     len data          mode exp_data      err lat
        vecs[0]  = '{2'b10,  8, 32'h000000A5, 2, 32'h000000A5, 1'b0, 13};
        vecs[1]  = '{2'b01,  4, 32'h00000003, 1, 32'h0000000F, 1'b0, 10};
        vecs[2]  = '{2'b00,  0, 32'h00000000, 1, 32'h00000000, 1'b0,  6};
        vecs[3]  = '{2'b11,  3, 32'h12345678, 1, 32'h00000000, 1'b0,  3};
        vecs[4]  = '{2'b10,  0, 32'hFFFFFFFF, 1, 32'h00000000, 1'b1,  1};
        vecs[5]  = '{2'b01, 33, 32'hFFFFFFFF, 1, 32'h00000000, 1'b1,  1};
        vecs[6]  = '{2'b10, 32, 32'hDEADBEEF, 2, 32'hDEADBEEF, 1'b0, 37};
        vecs[7]  = '{2'b01, 32, 32'h00000000, 1, 32'hFFFFFFFF, 1'b0, 38};
        vecs[8]  = '{2'b10,  1, 32'h00000001, 2, 32'h00000001, 1'b0,  6};
        vecs[9]  = '{2'b11, 32, 32'h00000000, 1, 32'h00000000, 1'b0, 32};
        vecs[10] = '{2'b11,  0, 32'h00000000, 0, 32'h00000000, 1'b1,  1};
        vecs[11] = '{2'b10,  5, 32'h0000001F, 0, 32'h00000000, 1'b0, 10};
        vecs[12] = '{2'b01,  7, 32'h00000055, 2, 32'h00000055, 1'b0, 13};

        // Power-up: three cycles in reset, then release.
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("powerup");
        end
        release_reset();

        // Directed vectors, issued back-to-back.
        for (int i = 0; i < 13; i++) begin
            run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].mode, 1'b0, gd, ge, gl);
            check($sformatf("vec%0d rsp_data", i), gd, vecs[i].exp_data);
            check($sformatf("vec%0d rsp_err", i), ge, vecs[i].exp_err);
            check($sformatf("vec%0d latency", i), gl, vecs[i].exp_lat);
        end

        // RESET then IDLE len=3 with cmd_valid held high throughout.
        nh_op = 2'b11; nh_len = 3; nh_data = 32'h0;
        run_cmd(2'b00, 0, 32'h0, 0, 1'b1, gd, ge, gl);
        a0 = acc_cyc;
        run_cmd(2'b11, 3, 32'h0, 0, 1'b0, gd, ge, gl);
        check("b2b second_rsp_after_first_accept", rsp_cyc - a0, 10);
        check("b2b idle latency", gl, 3);

        // Abort: TRST during shift bit 5 of SHIFT_DR len=16.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b10;
        bus.cmd_len   = LEN_W'(16);
        bus.cmd_data  = 32'h0000A5A5;
        tdo_mode      = 2;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("abort in_shdr", tap_state, 4);
        check("abort tdi_bit5", TDI, 1);
        TRST = 1'b1;
        #1;
        check_reset_outputs("abort");
        repeat (2) begin
            @(negedge clk);
            check("abort rsp_valid", bus.rsp_valid, 0);
            check("abort cmd_ready", bus.cmd_ready, 0);
        end
        last_rsp = '0;
        mtap     = 0;
        release_reset();
        run_cmd(2'b10, 1, 32'h1, 2, 1'b0, gd, ge, gl);
        check("after_abort rsp_data", gd, 1);
        check("after_abort latency", gl, 6);

        // Random commands, including illegal lengths and idle gaps.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    mtap = nx0[mtap];
                    @(negedge clk);
                    check("gap tms", TMS, 0);
                    check("gap tap_state", tap_state, mtap);
                end
            end
            run_cmd(2'($urandom), $urandom_range(0, 36), $urandom,
                    $urandom_range(0, 3), 1'b0, gd, ge, gl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
